// File: rtl/d_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : d_mem_pkg
// Brief    : Shared funct3 codes, state type and lane helpers for d_mem.
// Revision : 1.0 - initial release
// ============================================================================
package d_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [3:0] byte_strobe(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] s;
        case (f3)
            F3_B:    s = 4'b0001 << lo;
            F3_H:    s = lo[1] ? 4'b1100 : 4'b0011;
            F3_W:    s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*lo +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = word;
            F3_BU:   r = {24'd0, b};
            F3_HU:   r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/d_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : d_mem_array
// Brief    : Single-port DEPTH x 32 RAM, byte write enables, synchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module d_mem_array #(
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic [3:0]               i_we,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Read-first: a write and a read at the same edge return the old word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        o_rdata <= r_mem[i_idx];
    end

endmodule
`default_nettype wire

// File: rtl/d_mem.sv
`default_nettype none
// ============================================================================
// Module   : d_mem
// Brief    : Load/store data memory with handshake, error checks and clear FSM.
//            D_MEM_SKIP_INIT_EN removes the post-reset clear sequence.
// Revision : 1.0 - initial release
// ============================================================================
module d_mem
    import d_mem_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int IDX_W = $clog2(DEPTH);

    logic             w_accept;
    logic             w_err;
    logic             w_misalign;
    logic             w_bad_f3;
    logic             w_range;
    logic [IDX_W-1:0] w_req_idx;
    logic [3:0]       w_req_we;
    logic [31:0]      w_req_wdata;
    logic [3:0]       w_arr_we;
    logic [IDX_W-1:0] w_arr_idx;
    logic [31:0]      w_arr_wdata;
    logic [31:0]      w_arr_rdata;

    logic             r_p1_valid;
    logic             r_p1_err;
    logic             r_p1_load;
    logic [2:0]       r_p1_f3;
    logic [1:0]       r_p1_lo;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_err;

    assign w_req_idx  = req_addr[IDX_W+1:2];
    assign w_range    = (req_addr >> (IDX_W + 2)) != '0;
    assign w_misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign w_bad_f3   = req_we ? (req_funct3 > F3_W)
                               : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    assign w_err      = w_misalign || w_bad_f3 || w_range;
    assign w_accept   = req_valid && req_ready && !rst;
    assign w_req_we   = (w_accept && req_we && !w_err)
                      ? byte_strobe(req_funct3, req_addr[1:0]) : 4'b0000;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   w_req_wdata = {4{req_wdata[7:0]}};
            2'b01:   w_req_wdata = {2{req_wdata[15:0]}};
            default: w_req_wdata = req_wdata;
        endcase
    end

`ifndef D_MEM_SKIP_INIT_EN
    localparam logic [IDX_W-1:0] c_clr_last = IDX_W'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_clr_cnt;
    logic [IDX_W-1:0] w_clr_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // While clearing, the counter owns the single array port.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_arr_we      = w_req_we;
        w_arr_idx     = w_req_idx;
        w_arr_wdata   = w_req_wdata;
        case (r_state)
            INIT: begin
                w_arr_we      = 4'b1111;
                w_arr_idx     = r_clr_cnt;
                w_arr_wdata   = 32'd0;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == c_clr_last) begin
                    w_state_nxt = RUN;
                end
            end
            default: ;
        endcase
    end

    assign req_ready = (r_state == RUN);
    assign init_busy = (r_state == INIT);
`else
    assign w_arr_we    = w_req_we;
    assign w_arr_idx   = w_req_idx;
    assign w_arr_wdata = w_req_wdata;
    assign req_ready   = 1'b1;
    assign init_busy   = 1'b0;
`endif

    d_mem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_idx   (w_arr_idx),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    // Stage 1 tracks the in-flight array read; stage 2 registers the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_valid  <= 1'b0;
            r_p1_err    <= 1'b0;
            r_p1_load   <= 1'b0;
            r_p1_f3     <= 3'd0;
            r_p1_lo     <= 2'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_p1_valid  <= w_accept;
            r_p1_err    <= w_accept && w_err;
            r_p1_load   <= w_accept && !req_we && !w_err;
            r_p1_f3     <= req_funct3;
            r_p1_lo     <= req_addr[1:0];
            r_rsp_valid <= r_p1_valid;
            r_rsp_err   <= r_p1_err;
            r_rsp_rdata <= r_p1_load ? load_extend(r_p1_f3, r_p1_lo, w_arr_rdata) : 32'd0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_d_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_mem
// Brief    : Randomized self-checking bench for d_mem against a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_d_mem;

    localparam int DEPTH = 512;
    localparam int BYTES = DEPTH * 4;
`ifdef D_MEM_SKIP_INIT_EN
    localparam int INIT_CYC = 0;
`else
    localparam int INIT_CYC = DEPTH;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_busy;

    int checks = 0;
    int failures = 0;

    d_mem #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference model: byte-addressed memory plus a two-deep response delay line.
    logic [7:0]  mem_b [BYTES];
    bit          m_on = 1'b0;
    int          init_left = 0;
    logic        m_p1_v = 1'b0, m_p1_e = 1'b0, m_out_v = 1'b0, m_out_e = 1'b0;
    logic [31:0] m_p1_d = 32'd0, m_out_d = 32'd0;

    task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] d, output logic e);
        int size;
        logic illegal;
        logic [31:0] val;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        e = illegal || (addr % size != 0) || (addr >= BYTES);
        d = 32'd0;
        if (!e) begin
            if (we) begin
                for (int k = 0; k < size; k++) mem_b[addr + k] = 8'((wdata >> (8 * k)) & 32'hFF);
            end else begin
                val = 32'd0;
                for (int k = 0; k < size; k++) val = val | (32'(mem_b[addr + k]) << (8 * k));
                if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFFFFFF << (8 * size));
                d = val;
            end
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] d;
        logic        e;
        if (rst) begin
            m_on = 1'b1;
            m_p1_v = 0; m_p1_d = 0; m_p1_e = 0;
            m_out_v = 0; m_out_d = 0; m_out_e = 0;
            init_left = INIT_CYC;
`ifndef D_MEM_SKIP_INIT_EN
            for (int i = 0; i < BYTES; i++) mem_b[i] = 8'd0;
`endif
        end else begin
            m_out_v = m_p1_v; m_out_d = m_p1_d; m_out_e = m_p1_e;
            m_p1_v = 0; m_p1_d = 0; m_p1_e = 0;
            if (req_valid && init_left == 0) begin
                model_access(req_we, req_funct3, req_addr, req_wdata, d, e);
                m_p1_v = 1'b1; m_p1_d = d; m_p1_e = e;
            end
            if (init_left > 0) init_left--;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("cmp_valid", 32'(rsp_valid), 32'(m_out_v));
            chk("cmp_busy", 32'(init_busy), 32'(init_left > 0));
            chk("cmp_ready", 32'(req_ready), 32'(init_left == 0));
            if (m_out_v) begin
                chk("cmp_rdata", rsp_rdata, m_out_d);
                chk("cmp_err", 32'(rsp_err), 32'(m_out_e));
            end
        end
    end

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    endtask

    task automatic lit(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_d, input logic exp_e);
        @(negedge clk);
        drive(we, f3, addr, wdata);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_rdata"}, rsp_rdata, exp_d);
        chk({name, "_err"}, 32'(rsp_err), 32'(exp_e));
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [2:0] f3_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        int n;
        int r;
        logic [31:0] exp_after_rst;

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(init_busy), 32'(INIT_CYC > 0));
        chk("rst_ready", 32'(req_ready), 32'(INIT_CYC == 0));
        rst = 1'b0;
        wait_init(n);
        chk("init_cycles", 32'(n), 32'(INIT_CYC));

`ifdef D_MEM_SKIP_INIT_EN
        // Without a clear sequence, give the tested region defined contents first.
        for (int w = 0; w < 128; w++) begin
            @(negedge clk);
            drive(1'b1, 3'd2, 32'(w * 4), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
`endif

        lit("lw_1fc", 1'b0, 3'd2, 32'h1FC, 32'd0, 32'h0, 1'b0);

        // Store followed immediately by a load of the same word.
        @(negedge clk);
        drive(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        drive(1'b0, 3'd2, 32'h100, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("sw_100_valid", 32'(rsp_valid), 32'd1);
        chk("sw_100_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        chk("lw_100_valid", 32'(rsp_valid), 32'd1);
        chk("lw_100_rdata", rsp_rdata, 32'hDEADBEEF);

        lit("lb_103", 1'b0, 3'd0, 32'h103, 32'd0, 32'hFFFFFFDE, 1'b0);
        lit("lbu_101", 1'b0, 3'd4, 32'h101, 32'd0, 32'h000000BE, 1'b0);
        lit("sw_40", 1'b1, 3'd2, 32'h40, 32'h0, 32'h0, 1'b0);
        lit("sb_42", 1'b1, 3'd0, 32'h42, 32'h80, 32'h0, 1'b0);
        lit("sh_40", 1'b1, 3'd1, 32'h40, 32'h8001, 32'h0, 1'b0);
        lit("lw_40", 1'b0, 3'd2, 32'h40, 32'd0, 32'h00808001, 1'b0);
        lit("lh_40", 1'b0, 3'd1, 32'h40, 32'd0, 32'hFFFF8001, 1'b0);
        lit("lhu_42", 1'b0, 3'd5, 32'h42, 32'd0, 32'h00000080, 1'b0);
        lit("lh_101", 1'b0, 3'd1, 32'h101, 32'd0, 32'h0, 1'b1);
        lit("sw_102", 1'b1, 3'd2, 32'h102, 32'h11111111, 32'h0, 1'b1);
        lit("lw_100_kept", 1'b0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 1'b0);
        lit("lw_800", 1'b0, 3'd2, 32'h800, 32'd0, 32'h0, 1'b1);
        lit("ld_f3_011", 1'b0, 3'd3, 32'h0, 32'd0, 32'h0, 1'b1);
        lit("st_f3_100", 1'b1, 3'd4, 32'h0, 32'hFF, 32'h0, 1'b1);

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            r = int'($urandom % 16);
            req_valid  = ($urandom % 4) != 0;
            req_we     = 1'($urandom % 2);
            req_funct3 = (($urandom % 4) == 0) ? 3'($urandom % 8) : f3_tab[$urandom % 5];
            req_addr   = (r == 0) ? $urandom : (r == 1) ? 32'(BYTES + $urandom % 64)
                                             : 32'($urandom % 512);
            req_wdata  = $urandom;
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset lands while a load response is still in flight.
        lit("sw_10", 1'b1, 3'd2, 32'h10, 32'h12345678, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd2, 32'h10, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(init_busy), 32'(INIT_CYC > 0));
        rst = 1'b0;
        wait_init(n);
        chk("reinit_cycles", 32'(n), 32'(INIT_CYC));
`ifdef D_MEM_SKIP_INIT_EN
        exp_after_rst = 32'h12345678;
`else
        exp_after_rst = 32'h00000000;
`endif
        lit("lw_10_after_rst", 1'b0, 3'd2, 32'h10, 32'd0, exp_after_rst, 1'b0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
